// File: rtl/seq_divider.sv
// Radix-2 restoring divider, one quotient bit per clock, valid/ready on both sides.
// Define SEQ_DIVIDER_SIGNED_EN for two's-complement operands (adds a one-cycle FIX state).
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t           state, state_nx;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem_w, q_w, dvs_w;
  logic [WIDTH-1:0] rem_nx, q_nx;
  logic [WIDTH:0]   trial;
  logic             accept, last_iter, dvs_zero;

`ifdef SEQ_DIVIDER_SIGNED_EN
  logic neg_q, neg_r, ovf_w;

  function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction
`endif

  assign accept    = in_valid & in_ready;
  assign last_iter = (cnt == CW'(1));
  assign dvs_zero  = (divisor == '0);

  always_comb begin
    trial  = {rem_w, q_w[WIDTH-1]} - {1'b0, dvs_w};
    rem_nx = trial[WIDTH] ? {rem_w[WIDTH-2:0], q_w[WIDTH-1]} : trial[WIDTH-1:0];
    q_nx   = {q_w[WIDTH-2:0], ~trial[WIDTH]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (accept) state_nx = dvs_zero ? DONE : CALC;
`ifdef SEQ_DIVIDER_SIGNED_EN
      CALC: if (last_iter) state_nx = FIX;
`else
      CALC: if (last_iter) state_nx = DONE;
`endif
      FIX:  state_nx = DONE;
      DONE: if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  // Operand capture, iteration and result write-back
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      rem_w       <= '0;
      q_w         <= '0;
      dvs_w       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      ovf_w       <= 1'b0;
      overflow    <= 1'b0;
`endif
    end else if (accept) begin
      cnt         <= CW'(WIDTH);
      rem_w       <= '0;
      div_by_zero <= dvs_zero;
`ifdef SEQ_DIVIDER_SIGNED_EN
      overflow    <= 1'b0;
      q_w         <= apply_sign(dividend, dividend[WIDTH-1]);
      dvs_w       <= apply_sign(divisor, divisor[WIDTH-1]);
      neg_q       <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
      neg_r       <= dividend[WIDTH-1];
      ovf_w       <= (dividend == {1'b1, {(WIDTH-1){1'b0}}}) && (divisor == '1);
`else
      q_w         <= dividend;
      dvs_w       <= divisor;
`endif
      if (dvs_zero) begin
        quotient  <= '1;
        remainder <= dividend;
      end
    end else if (state == CALC) begin
      rem_w <= rem_nx;
      q_w   <= q_nx;
      cnt   <= cnt - 1'b1;
`ifndef SEQ_DIVIDER_SIGNED_EN
      if (last_iter) begin
        quotient  <= q_nx;
        remainder <= rem_nx;
      end
`endif
    end
`ifdef SEQ_DIVIDER_SIGNED_EN
    else if (state == FIX) begin
      // Magnitude result wraps to -2^(WIDTH-1) for the single overflow case
      quotient  <= apply_sign(q_w, neg_q);
      remainder <= apply_sign(rem_w, neg_r);
      overflow  <= ovf_w;
    end
`endif
  end

`ifndef SEQ_DIVIDER_SIGNED_EN
  assign overflow = 1'b0;
`endif

endmodule
